// File: rtl/bus_seq_arbiter.sv
// bus_seq_arbiter: round-robin sharing of one bus sequencer among NUM_REQ requesters
module bus_seq_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic                          err_o,
  output logic [NUM_REQ-1:0]            rd_valid_o,
  output logic [7:0]                    rd_data_o,
  output logic                          seq_start_o,
  output logic [ADDR_WIDTH-1:0]         seq_start_addr_o,
  input  logic                          seq_ready_i,
  input  logic                          seq_data_valid_i,
  input  logic [7:0]                    seq_data_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = ACK_TIMEOUT > 0 ? $clog2(ACK_TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, rr_q, rr_d, pick;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, rdv_q, rdv_d, owner;
  logic err_q, err_d, start_q, start_d, found;
  logic [7:0] rdd_q, rdd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [IW:0] s;
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
    assign addr_a[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
  end
  assign owner   = NUM_REQ'(1) << idx_q;
  assign cnt_inc = cnt_q + 1'b1;
  // Scan from the top offset down so the lowest offset from rr_q wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    s     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      s = {1'b0, rr_q} + (IW+1)'(i);
      s = (s >= (IW+1)'(NUM_REQ)) ? s - (IW+1)'(NUM_REQ) : s;
      if (req_i[s[IW-1:0]]) begin
        found = 1'b1;
        pick  = s[IW-1:0];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    done_d  = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: if (found) begin
        idx_d   = pick;
        addr_d  = addr_a[pick];
        gnt_d   = NUM_REQ'(1) << pick;
        state_d = START;
      end
      START: if (seq_ready_i) begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: if (!seq_ready_i) state_d = WAIT_DONE;
      else begin
        cnt_d = cnt_inc;
        if (ACK_TIMEOUT != 0 && cnt_inc == CW'(ACK_TIMEOUT)) begin
          err_d   = 1'b1;
          done_d  = owner;
          state_d = DONE;
        end
      end
      WAIT_DONE: if (seq_ready_i) begin
        done_d  = owner;
        state_d = DONE;
      end
      DONE: begin
        gnt_d   = '0;
        rr_d    = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Read bytes are forwarded only while a sequence is in flight.
  assign rdv_d = ((state_q == WAIT_ACK || state_q == WAIT_DONE) && seq_data_valid_i) ? owner : '0;
  assign rdd_d = (rdv_d != '0) ? seq_data_i : rdd_q;
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      rdv_q   <= '0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
    end
  end
  assign gnt_o            = gnt_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign rd_valid_o       = rdv_q;
  assign rd_data_o        = rdd_q;
  assign seq_start_o      = start_q;
  assign seq_start_addr_o = addr_q;
endmodule
